// File: rtl/dualport_ram_ext.sv
// dualport_ram_ext: two-port byte-enabled RAM with post-reset zero sweep,
// same-address write merging, collision flag and 1- or 2-cycle registered reads.
module dualport_ram_ext #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int COLLISION_PRIO = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   PORTA_W_ADDR,
    input  logic [DATA_WIDTH-1:0]   PORTA_W_DATA,
    input  logic [DATA_WIDTH/8-1:0] PORTA_W_BE,
    input  logic                    PORTA_W_EN,
    input  logic [ADDR_WIDTH-1:0]   PORTA_R_ADDR,
    input  logic                    PORTA_R_EN,
    output logic [DATA_WIDTH-1:0]   PORTA_R_DATA,
    output logic                    PORTA_R_VALID,
    input  logic [ADDR_WIDTH-1:0]   PORTB_W_ADDR,
    input  logic [DATA_WIDTH-1:0]   PORTB_W_DATA,
    input  logic [DATA_WIDTH/8-1:0] PORTB_W_BE,
    input  logic                    PORTB_W_EN,
    input  logic [ADDR_WIDTH-1:0]   PORTB_R_ADDR,
    input  logic                    PORTB_R_EN,
    output logic [DATA_WIDTH-1:0]   PORTB_R_DATA,
    output logic                    PORTB_R_VALID,
    output logic                    INIT_BUSY,
    output logic                    COLLISION
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]                 r_state;
    logic [ADDR_WIDTH-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
    logic                       r_coll;
    logic                       w_ready;
    logic                       w_same;
    logic [ADDR_WIDTH-1:0]      w_waddr [2];
    logic [ADDR_WIDTH-1:0]      w_raddr [2];
    logic [DATA_WIDTH-1:0]      w_wdata [2];
    logic [NB-1:0]              w_mask  [2];
    logic [NB-1:0]              w_keep  [2];
    logic [1:0]                 w_acc;
    logic [DATA_WIDTH-1:0]      w_old   [2];
    logic [DATA_WIDTH-1:0]      w_new   [2];
    logic [DATA_WIDTH-1:0]      w_rd    [2];
    logic [1:0][DATA_WIDTH-1:0] w_q_data;
    logic [1:0]                 w_q_vld;

    assign w_ready = r_state == ST_READY;
    assign w_same  = w_waddr[0] == w_waddr[1];

    // Gather both ports into arrays; strobes only count once the sweep is done
    always_comb begin
        w_waddr[0] = PORTA_W_ADDR;
        w_waddr[1] = PORTB_W_ADDR;
        w_raddr[0] = PORTA_R_ADDR;
        w_raddr[1] = PORTB_R_ADDR;
        w_wdata[0] = PORTA_W_DATA;
        w_wdata[1] = PORTB_W_DATA;
        w_mask[0]  = (w_ready && PORTA_W_EN) ? PORTA_W_BE : '0;
        w_mask[1]  = (w_ready && PORTB_W_EN) ? PORTB_W_BE : '0;
        w_acc[0]   = w_ready && PORTA_R_EN;
        w_acc[1]   = w_ready && PORTB_R_EN;
    end

    // Lanes each port actually commits: on a same-address clash the loser drops shared lanes
    always_comb begin
        w_keep[0] = w_mask[0] & ~((w_same && COLLISION_PRIO != 0) ? w_mask[1] : '0);
        w_keep[1] = w_mask[1] & ~((w_same && COLLISION_PRIO == 0) ? w_mask[0] : '0);
    end

    // Read view per port: stored word, or the word as it will look after this edge's writes
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_old[p] = r_mem[w_raddr[p]];
            w_new[p] = w_old[p];
            for (int i = 0; i < NB; i++) begin
                for (int q = 0; q < 2; q++) begin
                    if (w_keep[q][i] && w_waddr[q] == w_raddr[p])
                        w_new[p][8*i +: 8] = w_wdata[q][8*i +: 8];
                end
            end
            w_rd[p] = (RDW_MODE != 0) ? w_new[p] : w_old[p];
        end
    end

    // Sweep FSM: INIT walks the counter over every word, then READY until the next reset
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (CLEAR_ON_RESET == 0 || &r_cnt)
                r_state <= ST_READY;
        end
    end

    // Storage: zero-fill during the sweep, disjoint byte-lane writes from both ports when ready
    always_ff @(posedge ACLK) begin
        if (r_state == ST_INIT) begin
            if (CLEAR_ON_RESET != 0)
                r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_keep[0][i])
                    r_mem[w_waddr[0]][8*i +: 8] <= w_wdata[0][8*i +: 8];
                if (w_keep[1][i])
                    r_mem[w_waddr[1]][8*i +: 8] <= w_wdata[1][8*i +: 8];
            end
        end
    end

    // Collision flag: one-cycle pulse after a same-address write with overlapping lanes
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            r_coll <= 1'b0;
        else
            r_coll <= w_same && ((w_mask[0] & w_mask[1]) != '0);
    end

    genvar p;
    for (p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] r_s1_data;
        logic                  r_s1_vld;

        // First read stage: capture the selected word on an accepted read, else hold
        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                r_s1_data <= '0;
                r_s1_vld  <= 1'b0;
            end else begin
                r_s1_vld <= w_acc[p];
                if (w_acc[p])
                    r_s1_data <= w_rd[p];
            end
        end

        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] r_s2_data;
            logic                  r_s2_vld;

            // Second read stage: forwards stage-one results, holding data between valids
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    r_s2_data <= '0;
                    r_s2_vld  <= 1'b0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld)
                        r_s2_data <= r_s1_data;
                end
            end

            assign w_q_data[p] = r_s2_data;
            assign w_q_vld[p]  = r_s2_vld;
        end else begin : g_lat1
            assign w_q_data[p] = r_s1_data;
            assign w_q_vld[p]  = r_s1_vld;
        end
    end

    assign PORTA_R_DATA  = w_q_data[0];
    assign PORTA_R_VALID = w_q_vld[0];
    assign PORTB_R_DATA  = w_q_data[1];
    assign PORTB_R_VALID = w_q_vld[1];
    assign INIT_BUSY     = (r_state == ST_INIT) && (CLEAR_ON_RESET != 0);
    assign COLLISION     = r_coll;

endmodule

// File: tb/tb_dualport_ram_ext.sv
// tb_dualport_ram_ext: random and directed stimulus on two configurations, checked against a word/byte model
module tb_dualport_ram_ext;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int DEP  = 16;
    localparam int MAXC = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [AW-1:0] a_waddr, b_waddr, a_raddr, b_raddr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [3:0]    a_be, b_be;
    logic          a_wen, b_wen, a_ren, b_ren;

    logic [DW-1:0] a0_rd, b0_rd, a1_rd, b1_rd;
    logic          a0_rv, b0_rv, a1_rv, b1_rv, busy0, busy1, coll0, coll1;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [DW-1:0] mm [2][DEP];
    int            init_left;
    bit            acc [2][MAXC];
    logic [DW-1:0] dat [2][2][MAXC];
    logic [DW-1:0] e_data [2][2];
    bit            e_vld [2][2];
    bit            e_coll;

    always #5 clk = ~clk;

    dualport_ram_ext u_dut0 (
        .ACLK(clk), .ARESETN(rst_n),
        .PORTA_W_ADDR(a_waddr), .PORTA_W_DATA(a_wdata), .PORTA_W_BE(a_be), .PORTA_W_EN(a_wen),
        .PORTA_R_ADDR(a_raddr), .PORTA_R_EN(a_ren), .PORTA_R_DATA(a0_rd), .PORTA_R_VALID(a0_rv),
        .PORTB_W_ADDR(b_waddr), .PORTB_W_DATA(b_wdata), .PORTB_W_BE(b_be), .PORTB_W_EN(b_wen),
        .PORTB_R_ADDR(b_raddr), .PORTB_R_EN(b_ren), .PORTB_R_DATA(b0_rd), .PORTB_R_VALID(b0_rv),
        .INIT_BUSY(busy0), .COLLISION(coll0)
    );

    dualport_ram_ext #(.RD_LATENCY(2), .RDW_MODE(1), .COLLISION_PRIO(1)) u_dut1 (
        .ACLK(clk), .ARESETN(rst_n),
        .PORTA_W_ADDR(a_waddr), .PORTA_W_DATA(a_wdata), .PORTA_W_BE(a_be), .PORTA_W_EN(a_wen),
        .PORTA_R_ADDR(a_raddr), .PORTA_R_EN(a_ren), .PORTA_R_DATA(a1_rd), .PORTA_R_VALID(a1_rv),
        .PORTB_W_ADDR(b_waddr), .PORTB_W_DATA(b_wdata), .PORTB_W_BE(b_be), .PORTB_W_EN(b_wen),
        .PORTB_R_ADDR(b_raddr), .PORTB_R_EN(b_ren), .PORTB_R_DATA(b1_rd), .PORTB_R_VALID(b1_rv),
        .INIT_BUSY(busy1), .COLLISION(coll1)
    );

    function automatic int lat_of(int k);
        return k == 0 ? 1 : 2;
    endfunction

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic check_all();
        check("busy0", busy0, init_left > 0);
        check("busy1", busy1, init_left > 0);
        check("coll0", coll0, e_coll);
        check("coll1", coll1, e_coll);
        check("a0_vld", a0_rv, e_vld[0][0]);
        check("b0_vld", b0_rv, e_vld[0][1]);
        check("a1_vld", a1_rv, e_vld[1][0]);
        check("b1_vld", b1_rv, e_vld[1][1]);
        check("a0_data", a0_rd, e_data[0][0]);
        check("b0_data", b0_rd, e_data[0][1]);
        check("a1_data", a1_rd, e_data[1][0]);
        check("b1_data", b1_rd, e_data[1][1]);
    endtask

    task automatic clear_expect();
        init_left = DEP;
        e_coll    = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int q = 0; q < 2; q++) begin
                e_vld[k][q]  = 1'b0;
                e_data[k][q] = '0;
            end
    endtask

    task automatic model_edge();
        logic [DW-1:0] old_a, old_b;
        if (init_left > 0) begin
            for (int k = 0; k < 2; k++) mm[k][DEP - init_left] = '0;
            init_left--;
            acc[0][cyc] = 1'b0;
            acc[1][cyc] = 1'b0;
            e_coll = 1'b0;
        end else begin
            e_coll = a_wen && b_wen && a_waddr == b_waddr && (a_be & b_be) != 0;
            acc[0][cyc] = a_ren;
            acc[1][cyc] = b_ren;
            for (int k = 0; k < 2; k++) begin
                old_a = mm[k][a_raddr];
                old_b = mm[k][b_raddr];
                for (int i = 0; i < 4; i++) begin
                    if (a_wen && b_wen && a_be[i] && b_be[i] && a_waddr == b_waddr)
                        mm[k][a_waddr][8*i +: 8] = (k == 1) ? b_wdata[8*i +: 8] : a_wdata[8*i +: 8];
                    else begin
                        if (a_wen && a_be[i]) mm[k][a_waddr][8*i +: 8] = a_wdata[8*i +: 8];
                        if (b_wen && b_be[i]) mm[k][b_waddr][8*i +: 8] = b_wdata[8*i +: 8];
                    end
                end
                dat[k][0][cyc] = (k == 1) ? mm[k][a_raddr] : old_a;
                dat[k][1][cyc] = (k == 1) ? mm[k][b_raddr] : old_b;
            end
        end
        for (int k = 0; k < 2; k++)
            for (int q = 0; q < 2; q++) begin
                e_vld[k][q] = acc[q][cyc - (lat_of(k) - 1)];
                if (e_vld[k][q]) e_data[k][q] = dat[k][q][cyc - (lat_of(k) - 1)];
            end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        else begin
            acc[0][cyc] = 1'b0;
            acc[1][cyc] = 1'b0;
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        a_wen = 0; b_wen = 0; a_ren = 0; b_ren = 0;
        a_be = '0; b_be = '0; a_wdata = '0; b_wdata = '0;
        a_waddr = '0; b_waddr = '0; a_raddr = '0; b_raddr = '0;
    endtask

    task automatic rand_inputs();
        bit narrow;
        narrow  = 1'($urandom_range(0, 1));
        a_waddr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
        b_waddr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
        a_raddr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
        b_raddr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
        a_wdata = $urandom;
        b_wdata = $urandom;
        a_be    = 4'($urandom);
        b_be    = 4'($urandom);
        a_wen   = 1'($urandom_range(0, 1));
        b_wen   = 1'($urandom_range(0, 1));
        a_ren   = 1'($urandom_range(0, 1));
        b_ren   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_expect();
        #1;
        check_all();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int q = 0; q < 2; q++)
            for (int c = 0; c < MAXC; c++) acc[q][c] = 1'b0;
        idle();
        #1;
        do_reset();
        // sweep interrupted at clock 5 with strobes active, then a full restart
        repeat (5) begin rand_inputs(); tick(); end
        do_reset();
        repeat (16) begin rand_inputs(); tick(); end
        idle();
        // every word reads back zero after the sweep
        for (int a = 0; a < DEP; a++) begin
            a_ren = 1; a_raddr = AW'(a); b_ren = 1; b_raddr = AW'(DEP - 1 - a);
            tick();
            check("zero_a0", a0_rd, 32'h0);
        end
        idle(); tick(); tick();
        // full-word write then read on the other port
        a_wen = 1; a_waddr = 1; a_wdata = 32'hCAFEBABE; a_be = 4'hF;
        tick();
        idle(); b_ren = 1; b_raddr = 1;
        tick();
        check("cafe_b0", b0_rd, 32'hCAFEBABE);
        check("cafe_v0", b0_rv, 32'h1);
        idle(); tick();
        check("cafe_b1", b1_rd, 32'hCAFEBABE);
        check("cafe_v0_off", b0_rv, 32'h0);
        // partial byte-lane write
        a_wen = 1; a_waddr = 1; a_wdata = 32'h11223344; a_be = 4'h5;
        tick();
        idle(); a_ren = 1; a_raddr = 1;
        tick();
        check("be5_a0", a0_rd, 32'hCA22BA44);
        idle(); tick();
        // same-address full-overlap collision
        a_wen = 1; a_waddr = 3; a_wdata = 32'hFFFFFFFF; a_be = 4'hF;
        b_wen = 1; b_waddr = 3; b_wdata = 32'h00000000; b_be = 4'hF;
        tick();
        check("coll_pulse0", coll0, 32'h1);
        idle(); tick();
        check("coll_once0", coll0, 32'h0);
        a_ren = 1; a_raddr = 3;
        tick();
        check("prio0_word", a0_rd, 32'hFFFFFFFF);
        idle(); tick();
        check("prio1_word", a1_rd, 32'h00000000);
        // read-during-write on the same address
        a_wen = 1; a_waddr = 2; a_wdata = 32'h000000BA; a_be = 4'hF;
        tick();
        a_wdata = 32'h000000EA; b_ren = 1; b_raddr = 2;
        tick();
        check("rdw_old", b0_rd, 32'h000000BA);
        idle(); tick();
        check("rdw_new", b1_rd, 32'h000000EA);
        // random traffic with a reset landing on in-flight reads
        repeat (700) begin rand_inputs(); tick(); end
        rand_inputs();
        a_ren = 1; b_ren = 1;
        do_reset();
        repeat (16) begin rand_inputs(); tick(); end
        repeat (700) begin rand_inputs(); tick(); end
        idle(); tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
